// File: rtl/actuator_pkg.sv
// Shared definitions for the matrix actuator driver: FSM state encoding,
// H-bridge bit positions and the cell-index width helper.
package actuator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SELECT = 3'd2,
    ST_DEAD   = 3'd3,
    ST_PULSE  = 3'd4,
    ST_TAIL   = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Bit positions inside one 2-bit H-bridge pair.
  localparam int HB_HI = 0;
  localparam int HB_LO = 1;

  // Width of an index able to address 'count' items; never narrower than 1.
  function automatic int cell_idx_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/actuator_bridge_check.sv
// Safety checker: no H-bridge pair may ever drive high and low side together.
module actuator_bridge_check #(
  parameter int NUM_ROWS = 5,
  parameter int NUM_COLS = 2
) (
  input logic                  clock,
  input logic                  reset,
  input logic [2*NUM_ROWS-1:0] rows_hbridge,
  input logic [2*NUM_COLS-1:0] cols_hbridge
);

  logic shoot_through_s;

  // Flag any pair with both sides on.
  always_comb begin
    shoot_through_s = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      shoot_through_s = shoot_through_s | (rows_hbridge[2*r] & rows_hbridge[2*r+1]);
    end
    for (int c = 0; c < NUM_COLS; c++) begin
      shoot_through_s = shoot_through_s | (cols_hbridge[2*c] & cols_hbridge[2*c+1]);
    end
  end

  a_no_shoot_through: assert property (@(posedge clock) disable iff (reset) !shoot_through_s);

endmodule

// File: rtl/actuator_timer.sv
// Loadable down-counter used for the DEAD, PULSE and TAIL durations.
// A loaded value V gives V+1 cycles until zero_o is seen with the counter idle.
module actuator_timer #(
  parameter int TIMER_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] value_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] count_q;

  // Load on request, otherwise count down and stick at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - TIMER_W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/matrix_actuator_driver.sv
// NUM_ROWS x NUM_COLS actuator cell driver. Each cell gets SELECT, an all-off
// dead gap and a polarity-dependent drive pulse; a final dead gap precedes DONE.
// Optional feature macro: ACTUATOR_SKIP_UNCHANGED_EN (skip cells whose target
// equals the last applied state).
module matrix_actuator_driver
  import actuator_pkg::*;
#(
  parameter int NUM_ROWS = 5,
  parameter int NUM_COLS = 2,
  parameter int TIMER_W  = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_ROWS*NUM_COLS-1:0] cells_state,
  input  logic                         cell_invert,
  input  logic [TIMER_W-1:0]           pulse_cycles,
  input  logic [TIMER_W-1:0]           dead_cycles,
  output logic                         busy,
  output logic                         update_done,
  output logic [NUM_ROWS-1:0]          rows,
  output logic [NUM_COLS-1:0]          cols,
  output logic [NUM_ROWS-1:0]          rows_enable,
  output logic [NUM_COLS-1:0]          cols_enable,
  output logic [2*NUM_ROWS-1:0]        rows_hbridge,
  output logic [2*NUM_COLS-1:0]        cols_hbridge
);

  localparam int NCELLS = NUM_ROWS * NUM_COLS;
  localparam int IW     = cell_idx_w(NCELLS);
  localparam int RW     = cell_idx_w(NUM_ROWS);
  localparam int CW     = cell_idx_w(NUM_COLS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NCELLS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(NUM_COLS - 1);

  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  // Snapshot taken in LATCH; the update runs only from these.
  logic [NCELLS-1:0]  cells_q;
  logic               invert_q;
  logic [TIMER_W-1:0] pulse_q;
  logic [TIMER_W-1:0] dead_q;

  logic               timer_load_s;
  logic [TIMER_W-1:0] timer_value_s;
  logic               timer_zero_s;
  logic [TIMER_W-1:0] dead_eff_s;
  logic [TIMER_W-1:0] pulse_eff_s;
  logic               last_s;
  logic               skip_s;
  logic               eff_bit_s;

  logic                  busy_d, busy_q;
  logic                  done_d, done_q;
  logic [NUM_ROWS-1:0]   rows_d, rows_q;
  logic [NUM_COLS-1:0]   cols_d, cols_q;
  logic [2*NUM_ROWS-1:0] rhb_d, rhb_q;
  logic [2*NUM_COLS-1:0] chb_d, chb_q;

  // A zero duration still lasts one cycle, so the counter loads max(v,1)-1.
  assign dead_eff_s  = (dead_q  == '0) ? '0 : dead_q  - TIMER_W'(1);
  assign pulse_eff_s = (pulse_q == '0) ? '0 : pulse_q - TIMER_W'(1);
  assign last_s      = (idx_q == IDX_LAST);

  actuator_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load_i  (timer_load_s),
    .value_i (timer_value_s),
    .zero_o  (timer_zero_s)
  );

`ifdef ACTUATOR_SKIP_UNCHANGED_EN
  logic [NCELLS-1:0] applied_q;
  logic              applied_valid_q;

  assign skip_s = applied_valid_q && (cells_q[idx_q] == applied_q[idx_q]);

  // Remember what each cell was last driven to; valid once an update completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      applied_q       <= '0;
      applied_valid_q <= 1'b0;
    end else begin
      if (state_q == ST_PULSE && timer_zero_s) begin
        applied_q[idx_q] <= cells_q[idx_q];
      end
      if (state_q == ST_DONE) begin
        applied_valid_q <= 1'b1;
      end
    end
  end
`else
  assign skip_s = 1'b0;
`endif

  // Next-state, index advance and timer load decisions.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    row_d         = row_q;
    col_d         = col_q;
    timer_load_s  = 1'b0;
    timer_value_s = dead_eff_s;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LATCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        state_d = ST_SELECT;
        idx_d   = '0;
        row_d   = '0;
        col_d   = '0;
      end
      ST_SELECT: begin
        if (skip_s && last_s) begin
          state_d       = ST_TAIL;
          timer_load_s  = 1'b1;
          timer_value_s = dead_eff_s;
        end else if (skip_s) begin
          state_d = ST_SELECT;
          idx_d   = idx_q + IW'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          state_d       = ST_DEAD;
          timer_load_s  = 1'b1;
          timer_value_s = dead_eff_s;
        end
      end
      ST_DEAD: begin
        if (timer_zero_s) begin
          state_d       = ST_PULSE;
          timer_load_s  = 1'b1;
          timer_value_s = pulse_eff_s;
        end else begin
          state_d = ST_DEAD;
        end
      end
      ST_PULSE: begin
        if (timer_zero_s && last_s) begin
          state_d       = ST_TAIL;
          timer_load_s  = 1'b1;
          timer_value_s = dead_eff_s;
        end else if (timer_zero_s) begin
          state_d = ST_SELECT;
          idx_d   = idx_q + IW'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          state_d = ST_PULSE;
        end
      end
      ST_TAIL: begin
        if (timer_zero_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_TAIL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    eff_bit_s = cells_q[idx_d] ^ invert_q;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    rows_d    = '0;
    cols_d    = '0;
    rhb_d     = '0;
    chb_d     = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      rows_d[r]           = (state_d == ST_PULSE) && (r == int'(row_d));
      rhb_d[2*r + HB_HI]  = rows_d[r] &  eff_bit_s;
      rhb_d[2*r + HB_LO]  = rows_d[r] & ~eff_bit_s;
    end
    for (int c = 0; c < NUM_COLS; c++) begin
      cols_d[c]           = (state_d == ST_PULSE) && (c == int'(col_d));
      chb_d[2*c + HB_HI]  = cols_d[c] & ~eff_bit_s;
      chb_d[2*c + HB_LO]  = cols_d[c] &  eff_bit_s;
    end
  end

  // State, index and output registers; reset releases every bridge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rows_q  <= '0;
      cols_q  <= '0;
      rhb_q   <= '0;
      chb_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      rhb_q   <= rhb_d;
      chb_q   <= chb_d;
    end
  end

  // Snapshot of the update parameters, captured while in LATCH.
  always_ff @(posedge clock) begin
    if (reset) begin
      cells_q  <= '0;
      invert_q <= 1'b0;
      pulse_q  <= '0;
      dead_q   <= '0;
    end else if (state_q == ST_LATCH) begin
      cells_q  <= cells_state;
      invert_q <= cell_invert;
      pulse_q  <= pulse_cycles;
      dead_q   <= dead_cycles;
    end
  end

  assign busy         = busy_q;
  assign update_done  = done_q;
  assign rows         = rows_q;
  assign cols         = cols_q;
  assign rows_enable  = rows_q;
  assign cols_enable  = cols_q;
  assign rows_hbridge = rhb_q;
  assign cols_hbridge = chb_q;

  actuator_bridge_check #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS)) u_bridge_check (
    .clock        (clock),
    .reset        (reset),
    .rows_hbridge (rhb_q),
    .cols_hbridge (chb_q)
  );

endmodule

// File: tb/tb_matrix_actuator_driver.sv
// Scoreboard bench for matrix_actuator_driver (5x2, 32-bit timers).
module tb_matrix_actuator_driver;

  localparam int NR = 5;
  localparam int NC = 2;
  localparam int N  = NR * NC;
  localparam int TW = 32;

  logic          clock;
  logic          reset;
  logic          start;
  logic [N-1:0]  cells_state;
  logic          cell_invert;
  logic [TW-1:0] pulse_cycles;
  logic [TW-1:0] dead_cycles;
  logic          busy;
  logic          update_done;
  logic [NR-1:0] rows;
  logic [NC-1:0] cols;
  logic [NR-1:0] rows_enable;
  logic [NC-1:0] cols_enable;
  logic [2*NR-1:0] rows_hbridge;
  logic [2*NC-1:0] cols_hbridge;

  matrix_actuator_driver #(.NUM_ROWS(NR), .NUM_COLS(NC), .TIMER_W(TW)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .cells_state  (cells_state),
    .cell_invert  (cell_invert),
    .pulse_cycles (pulse_cycles),
    .dead_cycles  (dead_cycles),
    .busy         (busy),
    .update_done  (update_done),
    .rows         (rows),
    .cols         (cols),
    .rows_enable  (rows_enable),
    .cols_enable  (cols_enable),
    .rows_hbridge (rows_hbridge),
    .cols_hbridge (cols_hbridge)
  );

  typedef struct {
    bit          is_done;
    logic [NR-1:0]   rows;
    logic [NC-1:0]   cols;
    logic [2*NR-1:0] rhb;
    logic [2*NC-1:0] chb;
    int          len;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int start_cyc = 0;
  int done_cnt  = 0;
  int exp_dones = 0;
  logic [N-1:0] applied_m;
  bit           valid_m;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks = checks + 1;
    if (got !== want) begin
      failures = failures + 1;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Spec model: push expected pulses and the DONE latency for one update.
  task automatic push_exp(input logic [N-1:0] cells, input logic inv, input int d, input int p);
    int   deff, peff, lat;
    bit   skip;
    logic e;
    exp_t it;
    deff = (d == 0) ? 1 : d;
    peff = (p == 0) ? 1 : p;
    lat  = 1 + deff;
    for (int k = 0; k < N; k++) begin
`ifdef ACTUATOR_SKIP_UNCHANGED_EN
      skip = valid_m && (applied_m[k] == cells[k]);
`else
      skip = 1'b0;
`endif
      if (skip) begin
        lat = lat + 1;
      end else begin
        lat        = lat + 1 + deff + peff;
        e          = cells[k] ^ inv;
        it.is_done = 1'b0;
        it.rows    = NR'(1) << (k / NC);
        it.cols    = NC'(1) << (k % NC);
        it.rhb     = e ? ((2*NR)'(1) << (2*(k/NC))) : ((2*NR)'(1) << (2*(k/NC)+1));
        it.chb     = e ? ((2*NC)'(1) << (2*(k%NC)+1)) : ((2*NC)'(1) << (2*(k%NC)));
        it.len     = peff;
        it.lat     = 0;
        exp_q.push_back(it);
        applied_m[k] = cells[k];
      end
    end
    valid_m    = 1'b1;
    it.is_done = 1'b1;
    it.rows    = '0;
    it.cols    = '0;
    it.rhb     = '0;
    it.chb     = '0;
    it.len     = 0;
    it.lat     = lat;
    exp_q.push_back(it);
    exp_dones = exp_dones + 1;
  endtask

  task automatic kick(input bit hold);
    start = 1'b1;
    @(negedge clock);
    start_cyc = cyc;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input bit hold, input bit mutate);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (mutate && i == 2) begin
        cells_state  = ~cells_state;
        cell_invert  = ~cell_invert;
        dead_cycles  = 32'd7;
        pulse_cycles = 32'd9;
      end
      if (update_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    if (hold) start = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic run(input logic [N-1:0] cells, input logic inv, input int d, input int p,
                     input bit hold, input bit mutate);
    cells_state  = cells;
    cell_invert  = inv;
    dead_cycles  = TW'(d);
    pulse_cycles = TW'(p);
    push_exp(cells, inv, d, p);
    kick(hold);
    wait_done(hold, mutate);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, update_done}, 64'd0);
    check({tag, "_rows"}, 64'(rows), 64'd0);
    check({tag, "_cols"}, 64'(cols), 64'd0);
    check({tag, "_rows_en"}, 64'(rows_enable), 64'd0);
    check({tag, "_cols_en"}, 64'(cols_enable), 64'd0);
    check({tag, "_rows_hb"}, 64'(rows_hbridge), 64'd0);
    check({tag, "_cols_hb"}, 64'(cols_hbridge), 64'd0);
  endtask

  // Monitor: assemble pulses and DONE events and compare against the queue.
  initial begin
    bit   in_pulse;
    int   plen;
    exp_t cur, e;
    bit   conflict;
    in_pulse = 1'b0;
    plen     = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        in_pulse = 1'b0;
        plen     = 0;
      end else begin
        conflict = 1'b0;
        for (int r = 0; r < NR; r++) conflict |= rows_hbridge[2*r] & rows_hbridge[2*r+1];
        for (int c = 0; c < NC; c++) conflict |= cols_hbridge[2*c] & cols_hbridge[2*c+1];
        if (conflict) begin
          checks   = checks + 1;
          failures = failures + 1;
          $display("FAIL bridge_pair: got rhb=%b chb=%b want no pair 11", rows_hbridge, cols_hbridge);
        end
        if (rows != '0 || cols != '0 || rows_hbridge != '0 || cols_hbridge != '0) begin
          if (!in_pulse) begin
            in_pulse = 1'b1;
            plen     = 1;
            cur.rows = rows;
            cur.cols = cols;
            cur.rhb  = rows_hbridge;
            cur.chb  = cols_hbridge;
            check("rows_enable", 64'(rows_enable), 64'(rows));
            check("cols_enable", 64'(cols_enable), 64'(cols));
          end else begin
            plen = plen + 1;
            check("pulse_stable", {rows, cols, rows_hbridge, cols_hbridge},
                  {cur.rows, cur.cols, cur.rhb, cur.chb});
          end
        end else if (in_pulse) begin
          in_pulse = 1'b0;
          if (exp_q.size() == 0 || exp_q[0].is_done) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL unexpected_pulse: got rows=%b cols=%b want none", cur.rows, cur.cols);
          end else begin
            e = exp_q.pop_front();
            check("pulse_rows", 64'(cur.rows), 64'(e.rows));
            check("pulse_cols", 64'(cur.cols), 64'(e.cols));
            check("pulse_rows_hb", 64'(cur.rhb), 64'(e.rhb));
            check("pulse_cols_hb", 64'(cur.chb), 64'(e.chb));
            check("pulse_len", 64'(plen), 64'(e.len));
          end
        end
        if (update_done) begin
          done_cnt = done_cnt + 1;
          if (exp_q.size() == 0 || !exp_q[0].is_done) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL unexpected_done: got update_done at cycle %0d want pulse or nothing", cyc);
          end else begin
            e = exp_q.pop_front();
            check("done_latency", 64'(cyc - start_cyc), 64'(e.lat));
            check("done_busy", {63'd0, busy}, 64'd1);
          end
        end
      end
    end
  end

  initial begin
    bit found;
    applied_m    = '0;
    valid_m      = 1'b0;
    reset        = 1'b1;
    start        = 1'b0;
    cells_state  = '0;
    cell_invert  = 1'b0;
    pulse_cycles = '0;
    dead_cycles  = '0;
    repeat (3) @(negedge clock);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clock);

    // Single set cell, then inverted polarity; 63-cycle latency each.
    run(10'b0000000001, 1'b0, 2, 3, 1'b0, 1'b0);
    run(10'b0000000001, 1'b1, 2, 3, 1'b0, 1'b0);
    // Zero durations behave as one cycle.
    run(10'b1010011100, 1'b0, 0, 0, 1'b0, 1'b0);

    // Reset during the pulse of cell 3 (row 1, column 1).
    cells_state  = 10'b1111111111;
    cell_invert  = 1'b0;
    dead_cycles  = 32'd2;
    pulse_cycles = 32'd3;
    push_exp(10'b1111111111, 1'b0, 2, 3);
    kick(1'b0);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rows == 5'b00010 && cols == 2'b10) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("reach_cell3", {63'd0, found}, 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check_idle("midreset");
    exp_q.delete();
    exp_dones = exp_dones - 1;
    applied_m = '0;
    valid_m   = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run(10'b0101010101, 1'b0, 2, 3, 1'b0, 1'b0);

    // start held high and inputs changed after LATCH: one update, snapshot data.
    run(10'b0011001100, 1'b1, 1, 2, 1'b1, 1'b1);
    cells_state = 10'b0011001100;
    cell_invert = 1'b1;
    repeat (10) @(negedge clock);

`ifdef ACTUATOR_SKIP_UNCHANGED_EN
    run(10'b0000000001, 1'b0, 2, 3, 1'b0, 1'b0);
    run(10'b0000000001, 1'b0, 2, 3, 1'b0, 1'b0);
    run(10'b0010000001, 1'b0, 2, 3, 1'b0, 1'b0);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_cnt), 64'(exp_dones));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_actuator_driver.md
Name: matrix_actuator_driver

Overview:
Parametrised next-generation cell driver for the actuator matrix. It sequences per-cell set/reset pulses through row/column H-bridges using programmable pulse and dead-time durations. Generalises the fixed 5x2 cell controller to NUM_ROWS x NUM_COLS and adds explicit dead time, a start/busy handshake and optional skipping of unchanged cells. It sits between the memory controller (cell states, ccr timing words) and the pad-level row/column drivers.

Parameters:
NUM_ROWS, 5, number of matrix rows (>=1)
NUM_COLS, 2, number of matrix columns (>=1)
TIMER_W, 32, width of the pulse and dead-time counters

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  update request; sampled only in IDLE
cells_state  input  NUM_ROWS*NUM_COLS  target state; cell (r,c) = bit r*NUM_COLS+c; 1=set, 0=reset
cell_invert  input  1  swaps set/reset polarity for the whole update
pulse_cycles  input  TIMER_W  drive duration per cell (ccr0)
dead_cycles  input  TIMER_W  all-off gap before each pulse and after the last one (ccr1)
busy  output  1  high from the cycle after start is accepted until DONE inclusive
update_done  output  1  one-cycle pulse at end of update
rows  output  NUM_ROWS  one-hot row select during PULSE
cols  output  NUM_COLS  one-hot column select during PULSE
rows_enable  output  NUM_ROWS  row driver enable, equals rows
cols_enable  output  NUM_COLS  column driver enable, equals cols
rows_hbridge  output  2*NUM_ROWS  bit 2i = high side, 2i+1 = low side of row i
cols_hbridge  output  2*NUM_COLS  same encoding per column

Behaviour:
- Interface: one clock, named clock; reset is synchronous and active-high, named reset.
- Reset: every output is 0, FSM goes to IDLE and the cell index is 0. Reset mid-update releases all bridges at the next edge, with no update_done.
- FSM: IDLE -> LATCH -> SELECT -> DEAD -> PULSE -> (SELECT | TAIL) -> DONE -> IDLE.
- IDLE: start=1 -> LATCH. start is ignored in every other state.
- LATCH (1 cycle): snapshot cells_state, cell_invert, pulse_cycles and dead_cycles. Inputs may change after this with no effect. Set index to 0.
- SELECT (1 cycle): evaluate cell[index], then go to DEAD.
- DEAD: all bridges off, all selects and enables 0. Lasts max(dead_cycles,1) cycles.
- PULSE: lasts max(pulse_cycles,1) cycles. Row and column of the indexed cell are selected and enabled.
  - Effective bit e = state XOR invert.
  - e=1: row high side on, column low side on.
  - e=0: row low side on, column high side on.
  - All other bridge bits are 0.
- Bridge safety: no bridge pair ever has both bits set, including across state transitions. This is asserted in RTL.
- PULSE exit: if index = NUM_ROWS*NUM_COLS-1, go to TAIL. Otherwise increment index and go to SELECT.
- TAIL: all bridges off for max(dead_cycles,1) cycles, then DONE.
- DONE (1 cycle): update_done=1, busy=1, then IDLE.
- Latency (no skipping), with N = cell count, D = effective dead cycles, P = effective pulse cycles: DONE is entered 1+N·(1+D+P)+D cycles after the start-sampling edge.
- Counters: load the effective value minus 1 and count down to 0. Counter width is TIMER_W, with no wrap.

Optional Feature:
ACTUATOR_SKIP_UNCHANGED_EN
- Defined:
  - Keeps an applied_state register (NUM_ROWS*NUM_COLS bits) and an applied_valid flag; reset clears both.
  - In SELECT, if applied_valid=1 and the snapshot bit equals applied_state[index], the cell is skipped. It costs exactly the 1 SELECT cycle; the FSM then advances the index, or goes to TAIL if it was the last cell.
  - applied_state[index] is written at the end of each PULSE.
  - applied_valid is set in DONE.
  - cell_invert does not affect the skip comparison.
  - If all cells are skipped, the FSM still runs TAIL and DONE.
- Undefined: no skip logic and no applied_state storage; every cell is pulsed.

Decomposition:
- Package actuator_pkg holds:
  - the FSM state enum;
  - H-bridge bit-position constants (HB_HI=0, HB_LO=1);
  - the cell-index width function clog2(NUM_ROWS*NUM_COLS).
- Sub-module actuator_timer: loadable TIMER_W down-counter with load and zero outputs. It is shared by DEAD, PULSE and TAIL.
- Row and column are derived from index by division and modulo by NUM_COLS, or by nested counters.

Test Plan:
- Reset during PULSE of cell 3 -> next cycle all outputs 0, FSM in IDLE, no update_done; a following start runs the full sequence from cell 0.
- Defaults, cells_state=10'b0000000001, invert=0, D=2, P=3, start 1 cycle -> update_done 63 cycles after start edge.
  - Cell 0 pulse: rows=00001, cols=01, rows_hbridge[1:0]=01, cols_hbridge[1:0]=10.
  - Cells 1..9 show the reset polarity.
- Same stimulus with invert=1 -> cell 0 drives row low side and column high side; no pair ever reads 11.
- pulse_cycles=0, dead_cycles=0 -> each behaves as 1 cycle; DONE entered 1+10·3+1=32 cycles after start edge.
- start held high during an update, and cells_state changed after LATCH -> exactly one update_done per accepted start; pulses follow the snapshot.
- ACTUATOR_SKIP_UNCHANGED_EN: two identical updates -> second update has no PULSE cycles, DONE after 1+10+2=13 cycles (D=2). Flipping only cell 7 -> exactly one PULSE, on row 3 col 1.
